// File: rtl/trace_uart_tx_if.sv
// Capture bus carrying the retired-instruction pair from the CPU to the trace UART.
interface trace_uart_tx_if;
    logic [31:0] pc_in;
    logic [31:0] inst_in;
    logic        capture_en;

    modport master (output pc_in, output inst_in, output capture_en);
    modport slave  (input  pc_in, input  inst_in, input  capture_en);
endinterface

// File: rtl/trace_uart_tx.sv
// Trace UART: buffers {pc, inst} records in a FIFO and sends each one as 8N1 bytes, MSB byte first.
// Define TRACE_SYNC_EN to prefix every record with the sync byte 0xA5.
module trace_uart_tx #(
    parameter int BAUD_DIV = 868,
    parameter int FIFO_AW  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    trace_uart_tx_if.slave        cap_bus,
    output logic                  uart_tx,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  overflow,
    output logic                  busy
);
    localparam int                 DEPTH     = 1 << FIFO_AW;
    localparam logic [15:0]        BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [FIFO_AW:0]   CNT_FULL  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW + 1)'(1'b1);
    localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1'b1);
`ifdef TRACE_SYNC_EN
    localparam logic [3:0]         LAST_BYTE = 4'd8;
`else
    localparam logic [3:0]         LAST_BYTE = 4'd7;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [63:0]        mem_r [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r;
    logic [FIFO_AW-1:0] rd_ptr_r;
    logic [FIFO_AW:0]   count_r;
    logic [FIFO_AW:0]   count_nxt_s;
    logic               fifo_empty_r;
    logic               fifo_full_r;
    logic               overflow_r;
    logic               push_s;
    logic               pop_s;

    state_t             state_r;
    logic [63:0]        rec_r;
    logic [3:0]         byte_idx_r;
    logic [2:0]         bit_idx_r;
    logic [2:0]         bit_nxt_s;
    logic [15:0]        baud_cnt_r;
    logic               baud_done_s;
    logic [7:0]         tx_byte_s;
    logic               uart_tx_r;
    logic               busy_r;

    assign uart_tx    = uart_tx_r;
    assign fifo_empty = fifo_empty_r;
    assign fifo_full  = fifo_full_r;
    assign overflow   = overflow_r;
    assign busy       = busy_r;

    // FIFO handshake decode; full/empty are pre-edge so a same-edge pop never admits a push into a full FIFO
    always_comb begin
        push_s      = cap_bus.capture_en & ~fifo_full_r;
        pop_s       = (state_r == S_IDLE) & ~fifo_empty_r;
        baud_done_s = (baud_cnt_r == BAUD_LAST);
        bit_nxt_s   = bit_idx_r + 3'd1;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Byte currently on the wire, selected by byte_idx in transmit order
    always_comb begin
        tx_byte_s = 8'h00;
        case (byte_idx_r)
`ifdef TRACE_SYNC_EN
            4'd0:    tx_byte_s = 8'hA5;
            4'd1:    tx_byte_s = rec_r[63:56];
            4'd2:    tx_byte_s = rec_r[55:48];
            4'd3:    tx_byte_s = rec_r[47:40];
            4'd4:    tx_byte_s = rec_r[39:32];
            4'd5:    tx_byte_s = rec_r[31:24];
            4'd6:    tx_byte_s = rec_r[23:16];
            4'd7:    tx_byte_s = rec_r[15:8];
            4'd8:    tx_byte_s = rec_r[7:0];
`else
            4'd0:    tx_byte_s = rec_r[63:56];
            4'd1:    tx_byte_s = rec_r[55:48];
            4'd2:    tx_byte_s = rec_r[47:40];
            4'd3:    tx_byte_s = rec_r[39:32];
            4'd4:    tx_byte_s = rec_r[31:24];
            4'd5:    tx_byte_s = rec_r[23:16];
            4'd6:    tx_byte_s = rec_r[15:8];
            4'd7:    tx_byte_s = rec_r[7:0];
`endif
            default: tx_byte_s = 8'h00;
        endcase
    end

    // Record storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {cap_bus.pc_in, cap_bus.inst_in};
        end
    end

    // FIFO pointers, occupancy flags and sticky drop flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r     <= {FIFO_AW{1'b0}};
            rd_ptr_r     <= {FIFO_AW{1'b0}};
            count_r      <= {(FIFO_AW + 1){1'b0}};
            fifo_empty_r <= 1'b1;
            fifo_full_r  <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r      <= count_nxt_s;
            fifo_empty_r <= (count_nxt_s == {(FIFO_AW + 1){1'b0}});
            fifo_full_r  <= (count_nxt_s == CNT_FULL);
            if (cap_bus.capture_en && fifo_full_r) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Transmit FSM with registered line and busy outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            rec_r      <= 64'h0;
            byte_idx_r <= 4'd0;
            bit_idx_r  <= 3'd0;
            baud_cnt_r <= 16'd0;
            uart_tx_r  <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    baud_cnt_r <= 16'd0;
                    if (pop_s) begin
                        rec_r      <= mem_r[rd_ptr_r];
                        byte_idx_r <= 4'd0;
                        state_r    <= S_START;
                        uart_tx_r  <= 1'b0;
                        busy_r     <= 1'b1;
                    end else begin
                        uart_tx_r <= 1'b1;
                        busy_r    <= 1'b0;
                    end
                end
                S_START: begin
                    if (baud_done_s) begin
                        baud_cnt_r <= 16'd0;
                        bit_idx_r  <= 3'd0;
                        state_r    <= S_DATA;
                        uart_tx_r  <= tx_byte_s[0];
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 16'd1;
                    end
                end
                S_DATA: begin
                    if (baud_done_s) begin
                        baud_cnt_r <= 16'd0;
                        if (bit_idx_r == 3'd7) begin
                            state_r   <= S_STOP;
                            uart_tx_r <= 1'b1;
                        end else begin
                            bit_idx_r <= bit_nxt_s;
                            uart_tx_r <= tx_byte_s[bit_nxt_s];
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 16'd1;
                    end
                end
                S_STOP: begin
                    if (baud_done_s) begin
                        baud_cnt_r <= 16'd0;
                        if (byte_idx_r < LAST_BYTE) begin
                            byte_idx_r <= byte_idx_r + 4'd1;
                            state_r    <= S_START;
                            uart_tx_r  <= 1'b0;
                        end else begin
                            state_r   <= S_IDLE;
                            uart_tx_r <= 1'b1;
                            busy_r    <= 1'b0;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r    <= S_IDLE;
                    baud_cnt_r <= 16'd0;
                    uart_tx_r  <= 1'b1;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_trace_uart_tx.sv
// Bench for trace_uart_tx: record-level FIFO/transmit model plus a UART line decoder.
module tb_trace_uart_tx;
    localparam int BD    = 4;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
`ifdef TRACE_SYNC_EN
    localparam int NB    = 9;
`else
    localparam int NB    = 8;
`endif
    localparam int FRAME = 10 * BD;
    localparam int REC   = NB * FRAME;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic uart_tx, fifo_empty, fifo_full, overflow, busy;

    trace_uart_tx_if bus ();

    trace_uart_tx #(.BAUD_DIV(BD), .FIFO_AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cap_bus    (bus.slave),
        .uart_tx    (uart_tx),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [63:0] mq[$];
    logic [7:0]  exp_q[$];
    int          exp_start[$];
    int          tx_rem = 0;
    logic        m_ovf = 1'b0;

    // decoder output
    logic [7:0]  rx_q[$];
    int          rx_cyc[$];
    int          frame_err = 0;

    // Line decoder: mid-bit sampling on the falling clock edge, frames abandoned on reset
    initial begin
        logic [7:0] b;
        int         s;
        bit         ok;
        forever begin
            @(negedge clk);
            if (!rst && uart_tx === 1'b0) begin
                s  = cyc;
                ok = 1'b1;
                b  = 8'h00;
                for (int k = 1; k < 40 && ok; k++) begin
                    @(negedge clk);
                    if (rst) ok = 1'b0;
                    else if (k >= 6 && k <= 34 && ((k - 6) % 4) == 0) b = {uart_tx, b[7:1]};
                    else if (k == 38 && uart_tx !== 1'b1) frame_err++;
                end
                if (ok) begin
                    rx_q.push_back(b);
                    rx_cyc.push_back(s);
                end
            end
        end
    end

    task automatic step(input logic cap, input logic [31:0] pc, input logic [31:0] inst);
        logic [63:0] r;
        int pre;
        bus.capture_en = cap;
        bus.pc_in      = pc;
        bus.inst_in    = inst;
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
            tx_rem = 0;
            m_ovf  = 1'b0;
        end else begin
            pre = mq.size();
            if (tx_rem == 0 && pre > 0) begin
                r = mq.pop_front();
`ifdef TRACE_SYNC_EN
                exp_q.push_back(8'hA5);
`endif
                for (int i = 7; i >= 0; i--) exp_q.push_back(r[i*8 +: 8]);
                exp_start.push_back(cyc);
                tx_rem = REC;
            end else if (tx_rem > 0) begin
                tx_rem--;
            end
            if (cap) begin
                if (pre < DEPTH) mq.push_back({pc, inst});
                else m_ovf = 1'b1;
            end
        end
        bus.capture_en = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step(1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        rx_q.delete();
        rx_cyc.delete();
        exp_q.delete();
        exp_start.delete();
        frame_err = 0;
    endtask

    task automatic drain(input int maxc, output bit to);
        int n = 0;
        while ((mq.size() != 0 || tx_rem != 0) && n < maxc) begin
            step(1'b0, 32'h0, 32'h0);
            n++;
        end
        to = (n >= maxc);
        repeat (4) step(1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        do_reset(2);
        checks++;
        if ({uart_tx, fifo_empty, fifo_full, overflow, busy} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_state got=%b exp=%b", {uart_tx, fifo_empty, fifo_full, overflow, busy}, 5'b11000);
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 32'h0, 32'h0);
            checks++;
            if ({uart_tx, fifo_empty, fifo_full, overflow, busy} !== 5'b11000) begin
                errors++;
                $display("FAIL reset_idle cycle=%0d got=%b exp=%b", i, {uart_tx, fifo_empty, fifo_full, overflow, busy}, 5'b11000);
            end
        end
    endtask

    task automatic test_single();
        int busy_cnt = 0;
        do_reset(1);
        step(1'b1, 32'h00400000, 32'h3C011001);
        checks++;
        if ({fifo_empty, busy} !== {mq.size() == 0, tx_rem > 0}) begin
            errors++;
            $display("FAIL single_push got=%b exp=%b", {fifo_empty, busy}, {mq.size() == 0, tx_rem > 0});
        end
        step(1'b0, 32'h0, 32'h0);
        checks++;
        if ({uart_tx, busy} !== 2'b01) begin
            errors++;
            $display("FAIL single_start got=%b exp=%b", {uart_tx, busy}, 2'b01);
        end
        if (busy === 1'b1) busy_cnt = 1;
        for (int i = 0; i < REC + 8; i++) begin
            step(1'b0, 32'h0, 32'h0);
            if (busy === 1'b1) busy_cnt++;
            checks++;
            if ({fifo_empty, fifo_full, overflow, busy} !== {mq.size() == 0, mq.size() == DEPTH, m_ovf, tx_rem > 0}) begin
                errors++;
                $display("FAIL single_status cycle=%0d got=%b exp=%b", i, {fifo_empty, fifo_full, overflow, busy},
                         {mq.size() == 0, mq.size() == DEPTH, m_ovf, tx_rem > 0});
            end
        end
        checks++;
        if (busy_cnt != REC) begin
            errors++;
            $display("FAIL single_busy_len got=%0d exp=%0d", busy_cnt, REC);
        end
        checks++;
        if (rx_q.size() != exp_q.size() || rx_cyc.size() == 0 || exp_start.size() == 0) begin
            errors++;
            $display("FAIL single_count got=%0d exp=%0d", rx_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (rx_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL single_byte idx=%0d got=%h exp=%h", i, rx_q[i], exp_q[i]);
                end
            end
            checks++;
            if (rx_cyc[0] != exp_start[0]) begin
                errors++;
                $display("FAIL single_latency got=%0d exp=%0d", rx_cyc[0], exp_start[0]);
            end
        end
        checks++;
        if (frame_err != 0) begin
            errors++;
            $display("FAIL single_stop_bits got=%0d exp=%0d", frame_err, 0);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] base;
        bit to;
        do_reset(1);
        base = $urandom;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, base + 32'(i * 4), $urandom);
            checks++;
            if ({fifo_full, fifo_empty, overflow} !== {mq.size() == DEPTH, mq.size() == 0, m_ovf}) begin
                errors++;
                $display("FAIL ovf_status edge=%0d got=%b exp=%b", i, {fifo_full, fifo_empty, overflow},
                         {mq.size() == DEPTH, mq.size() == 0, m_ovf});
            end
            if (i == 16) begin
                checks++;
                if (fifo_full !== 1'b1) begin
                    errors++;
                    $display("FAIL ovf_full_e16 got=%b exp=%b", fifo_full, 1'b1);
                end
            end
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got=%b exp=%b", overflow, 1'b1);
        end
        drain(17 * (REC + 1) + 100, to);
        checks++;
        if (to || rx_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL ovf_drain timeout=%0d got=%0d exp=%0d", to, rx_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (rx_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL ovf_byte idx=%0d got=%h exp=%h", i, rx_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_after_drain got=%b exp=%b", overflow, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        do_reset(1);
        step(1'b1, $urandom, $urandom);
        step(1'b1, $urandom, $urandom);
        drain(3 * REC, to);
        checks++;
        if (to || rx_q.size() != 2 * NB || exp_q.size() != 2 * NB) begin
            errors++;
            $display("FAIL b2b_count timeout=%0d got=%0d exp=%0d", to, rx_q.size(), 2 * NB);
        end else begin
            for (int i = 0; i < 2 * NB; i++) begin
                checks++;
                if (rx_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL b2b_byte idx=%0d got=%h exp=%h", i, rx_q[i], exp_q[i]);
                end
            end
            checks++;
            if (rx_cyc[NB] - rx_cyc[0] != REC + 1) begin
                errors++;
                $display("FAIL b2b_gap got=%0d exp=%0d", rx_cyc[NB] - rx_cyc[0], REC + 1);
            end
            checks++;
            if (rx_cyc[2*NB-1] + FRAME - rx_cyc[0] != 2 * REC + 1) begin
                errors++;
                $display("FAIL b2b_total got=%0d exp=%0d", rx_cyc[2*NB-1] + FRAME - rx_cyc[0], 2 * REC + 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        int target;
        int n = 0;
        bit to;
        do_reset(1);
        for (int i = 0; i < 18; i++) step(1'b1, $urandom, $urandom);
        target = (exp_start.size() > 0) ? exp_start[0] + 3 * FRAME + BD + 6 : cyc;
        while (cyc < target && n < 500) begin
            step(1'b0, 32'h0, 32'h0);
            n++;
        end
        checks++;
        if ({busy, overflow, uart_tx === uart_tx} !== 3'b111 || n >= 500) begin
            errors++;
            $display("FAIL mid_precond got=%b exp=%b", {busy, overflow, 1'b1}, 3'b111);
        end
        do_reset(1);
        checks++;
        if ({uart_tx, fifo_empty, fifo_full, overflow, busy} !== 5'b11000) begin
            errors++;
            $display("FAIL mid_reset got=%b exp=%b", {uart_tx, fifo_empty, fifo_full, overflow, busy}, 5'b11000);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 32'h0, 32'h0);
            checks++;
            if ({uart_tx, fifo_empty, busy} !== 3'b110) begin
                errors++;
                $display("FAIL mid_idle cycle=%0d got=%b exp=%b", i, {uart_tx, fifo_empty, busy}, 3'b110);
            end
        end
        step(1'b1, $urandom, $urandom);
        drain(2 * REC, to);
        checks++;
        if (to || rx_q.size() != exp_q.size() || exp_q.size() != NB) begin
            errors++;
            $display("FAIL mid_fresh_count timeout=%0d got=%0d exp=%0d", to, rx_q.size(), NB);
        end else begin
            for (int i = 0; i < NB; i++) begin
                checks++;
                if (rx_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL mid_fresh_byte idx=%0d got=%h exp=%h", i, rx_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        bus.capture_en = 1'b0;
        bus.pc_in      = 32'h0;
        bus.inst_in    = 32'h0;
        test_reset();
        test_single();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
